datmem_word_arbiter: RTL and testbench

Two-port word-access arbiter and sequencer in front of the byte-wide data memory. Two requesters (port 0: processor load/store path; port 1: loader/debug port) each issue 32-bit word reads or writes; the block arbitrates round-robin. It converts each granted word into four big-endian byte accesses on the single byte memory port, then returns read data and a one-cycle acknowledge.

---
 rtl/datmem_word_arbiter.sv | 249 ++++++++++++++++++++++++
 tb/tb_datmem_word_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datmem_word_arbiter.sv
// datmem_word_arbiter
// Two-port round-robin word arbiter in front of a byte-wide data memory.
// Each granted 32-bit word is split into four big-endian byte accesses
// (most-significant byte at the base address), then the owner gets a
// one-cycle acknowledge. Read words are assembled byte by byte into the
// owner's read-data register.
module datmem_word_arbiter #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [31:0]       rdata0,
  output logic [31:0]       rdata1,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Byte k of a word, big-endian: k = 0 is bits 31:24.
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      2'd3:    b = word[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Replace byte k of a word, big-endian; other bytes keep their value.
  function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] k,
                                           input logic [7:0] b);
    logic [31:0] w;
    w = word;
    case (k)
      2'd0:    w[31:24] = b;
      2'd1:    w[23:16] = b;
      2'd2:    w[15:8]  = b;
      2'd3:    w[7:0]   = b;
      default: w = word;
    endcase
    return w;
  endfunction

  logic [1:0]        state_r;
  logic [1:0]        cnt_r;
  logic              owner_r;
  logic              we_r;
  logic [ADDR_W-1:0] base_r;
  logic [31:0]       wdata_r;
  logic              last_grant_r;
  logic              ack0_r;
  logic              ack1_r;
  logic [31:0]       rdata0_r;
  logic [31:0]       rdata1_r;
  logic              busy_r;
  logic              mem_en_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [7:0]        mem_wdata_r;

  logic              grant_port_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [31:0]       sel_wdata_s;
  logic [1:0]        next_cnt_s;
  logic              grant_take_s;
  logic [1:0]        state_nxt_s;
  logic [1:0]        cnt_nxt_s;
  logic              mem_en_nxt_s;
  logic              mem_we_nxt_s;
  logic [ADDR_W-1:0] mem_addr_nxt_s;
  logic [7:0]        mem_wdata_nxt_s;
  logic              ack0_nxt_s;
  logic              ack1_nxt_s;

  assign next_cnt_s = cnt_r + 2'd1;

  // Round-robin choice: a lone requester wins, a tie goes to the port not granted last.
  always_comb begin
    grant_port_s = 1'b0;
    if (req0 && req1) begin
      grant_port_s = ~last_grant_r;
    end else if (req1) begin
      grant_port_s = 1'b1;
    end else begin
      grant_port_s = 1'b0;
    end
    if (grant_port_s) begin
      sel_we_s    = we1;
      sel_addr_s  = addr1;
      sel_wdata_s = wdata1;
    end else begin
      sel_we_s    = we0;
      sel_addr_s  = addr0;
      sel_wdata_s = wdata0;
    end
  end

  // Next state plus next values of the registered memory strobes and acks.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    grant_take_s    = 1'b0;
    mem_en_nxt_s    = 1'b0;
    mem_we_nxt_s    = 1'b0;
    mem_addr_nxt_s  = {ADDR_W{1'b0}};
    mem_wdata_nxt_s = 8'h00;
    ack0_nxt_s      = 1'b0;
    ack1_nxt_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req0 || req1) begin
          grant_take_s    = 1'b1;
          state_nxt_s     = ST_XFER;
          cnt_nxt_s       = 2'd0;
          mem_en_nxt_s    = 1'b1;
          mem_we_nxt_s    = sel_we_s;
          mem_addr_nxt_s  = sel_addr_s;
          mem_wdata_nxt_s = word_byte(sel_wdata_s, 2'd0);
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_XFER: begin
        cnt_nxt_s = next_cnt_s;
        if (cnt_r == 2'd3) begin
          state_nxt_s = ST_DONE;
          ack0_nxt_s  = ~owner_r;
          ack1_nxt_s  = owner_r;
        end else begin
          // Present the following byte so the strobes stay registered.
          mem_en_nxt_s    = 1'b1;
          mem_we_nxt_s    = we_r;
          mem_addr_nxt_s  = base_r + ADDR_W'(next_cnt_s);
          mem_wdata_nxt_s = word_byte(wdata_r, next_cnt_s);
        end
      end
      ST_DONE: begin
        // Requests are deliberately not sampled on the edge leaving DONE.
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 2'd0;
      end
    endcase
  end

  // FSM state and byte counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Latch the granted transaction; later requester changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_r      <= 1'b0;
      we_r         <= 1'b0;
      base_r       <= {ADDR_W{1'b0}};
      wdata_r      <= 32'h0000_0000;
      last_grant_r <= 1'b1;
    end else if (grant_take_s) begin
      owner_r      <= grant_port_s;
      we_r         <= sel_we_s;
      base_r       <= sel_addr_s;
      wdata_r      <= sel_wdata_s;
      last_grant_r <= grant_port_s;
    end
  end

  // Registered byte-memory port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= 8'h00;
    end else begin
      mem_en_r    <= mem_en_nxt_s;
      mem_we_r    <= mem_we_nxt_s;
      mem_addr_r  <= mem_addr_nxt_s;
      mem_wdata_r <= mem_wdata_nxt_s;
    end
  end

  // Completion pulses and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack0_r <= 1'b0;
      ack1_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      ack0_r <= ack0_nxt_s;
      ack1_r <= ack1_nxt_s;
      busy_r <= (state_nxt_s != ST_IDLE);
    end
  end

  // Read assembly: capture the returned byte into the owner's word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0_r <= 32'h0000_0000;
      rdata1_r <= 32'h0000_0000;
    end else if ((state_r == ST_XFER) && !we_r) begin
      if (owner_r) begin
        rdata1_r <= put_byte(rdata1_r, cnt_r, mem_rdata);
      end else begin
        rdata0_r <= put_byte(rdata0_r, cnt_r, mem_rdata);
      end
    end
  end

  assign ack0      = ack0_r;
  assign ack1      = ack1_r;
  assign rdata0    = rdata0_r;
  assign rdata1    = rdata1_r;
  assign busy      = busy_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_datmem_word_arbiter.sv
// Directed self-checking bench for datmem_word_arbiter with a 32-byte
// behavioural memory and a log of every byte write.
`timescale 1ns/1ps
module tb_datmem_word_arbiter;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [31:0]       wdata0, wdata1;
  logic              ack0, ack1, busy, mem_en, mem_we;
  logic [31:0]       rdata0, rdata1;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem [0:31];
  logic       pl_en = 1'b0;
  logic [4:0] pl_addr = 5'd0;
  logic [7:0] pl_data = 8'h00;
  int         cyc = 0;
  int         wl_n = 0;
  logic [4:0] wl_addr [0:255];
  logic [7:0] wl_data [0:255];
  int         wl_cyc  [0:255];

  datmem_word_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Byte memory, preload port and write logger.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pl_en) mem[pl_addr] <= pl_data;
    if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
      if (wl_n < 256) begin
        wl_addr[wl_n] <= mem_addr;
        wl_data[wl_n] <= mem_wdata;
        wl_cyc[wl_n]  <= cyc + 1;
        wl_n          <= wl_n + 1;
      end
    end
  end

  assign mem_rdata = mem[mem_addr];

  task automatic poke(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Bounded wait for the given port's ack; reports whether the other port acked.
  task automatic wait_ack(input int port, output bit got, output int at_cyc, output bit other);
    got = 1'b0; other = 1'b0; at_cyc = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if ((port == 0) ? ack1 : ack0) other = 1'b1;
      if ((port == 0) ? ack0 : ack1) begin
        got = 1'b1;
        at_cyc = cyc;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 5'd0; addr1 = 5'd0; wdata0 = 32'h0; wdata1 = 32'h0;
    #12;
    n_cmp++;
    if ({ack0, ack1, busy, mem_en, mem_we} !== 5'b00000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 00000", {ack0, ack1, busy, mem_en, mem_we});
    end
    n_cmp++;
    if ({rdata0, rdata1} !== 64'h0) begin
      n_bad++; $display("FAIL reset_rdata: got %h want 0", {rdata0, rdata1});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata} !== 13'h0) begin
      n_bad++; $display("FAIL reset_mem: got addr %h wdata %h want 0", mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_write;
    logic [4:0] ea [4];
    logic [7:0] ed [4];
    int s, c0, at; bit got, oth;
    ea = '{5'd4, 5'd5, 5'd6, 5'd7};
    ed = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    s = wl_n;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd4; wdata0 = 32'hDEADBEEF;
    @(negedge clk);
    c0 = cyc;
    n_cmp++;
    if ({busy, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 5'd4, 8'hDE}) begin
      n_bad++; $display("FAIL wr_first_byte: got en%b we%b a%0d d%h busy%b want en1 we1 a4 dDE busy1",
                        mem_en, mem_we, mem_addr, mem_wdata, busy);
    end
    wait_ack(0, got, at, oth);
    n_cmp++;
    if (!got || (at - c0) != 4) begin
      n_bad++; $display("FAIL wr_ack_latency: got seen=%0d delta=%0d want seen=1 delta=4", got, at - c0);
    end
    req0 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ack0 !== 1'b0 || oth || ack1 !== 1'b0) begin
      n_bad++; $display("FAIL wr_ack_width: got ack0=%b ack1_seen=%0d want 0/0", ack0, oth);
    end
    n_cmp++;
    if (wl_n - s != 4) begin
      n_bad++; $display("FAIL wr_count: got %0d writes want 4", wl_n - s);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (wl_addr[s+i] !== ea[i] || wl_data[s+i] !== ed[i] || wl_cyc[s+i] != c0 + 1 + i) begin
          n_bad++; $display("FAIL wr_byte%0d: got %h@%0d cyc%0d want %h@%0d cyc%0d", i,
                            wl_data[s+i], wl_addr[s+i], wl_cyc[s+i], ed[i], ea[i], c0 + 1 + i);
        end
      end
    end
  endtask

  task automatic test_read;
    int at; bit got, oth;
    poke(5'd8, 8'h11); poke(5'd9, 8'h22); poke(5'd10, 8'h33); poke(5'd11, 8'h44);
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd8;
    wait_ack(1, got, at, oth);
    n_cmp++;
    if (!got || rdata1 !== 32'h11223344) begin
      n_bad++; $display("FAIL rd_data: got ack=%0d rdata1=%h want ack=1 11223344", got, rdata1);
    end
    req1 = 1'b0;
    n_cmp++;
    if (rdata0 !== 32'h0 || oth) begin
      n_bad++; $display("FAIL rd_other_port: got rdata0=%h ack0_seen=%0d want 0/0", rdata0, oth);
    end
    @(negedge clk);
    n_cmp++;
    if (rdata1 !== 32'h11223344 || ack1 !== 1'b0) begin
      n_bad++; $display("FAIL rd_hold: got rdata1=%h ack1=%b want 11223344/0", rdata1, ack1);
    end
  endtask

  task automatic test_wrap;
    logic [4:0] ea [4];
    logic [7:0] ed [4];
    int s, at; bit got, oth;
    ea = '{5'd30, 5'd31, 5'd0, 5'd1};
    ed = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    s = wl_n;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd30; wdata0 = 32'hA1B2C3D4;
    wait_ack(0, got, at, oth);
    req0 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (!got || wl_n - s != 4) begin
      n_bad++; $display("FAIL wrap_count: got ack=%0d writes=%0d want 1/4", got, wl_n - s);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (wl_addr[s+i] !== ea[i] || wl_data[s+i] !== ed[i]) begin
          n_bad++; $display("FAIL wrap_byte%0d: got %h@%0d want %h@%0d", i,
                            wl_data[s+i], wl_addr[s+i], ed[i], ea[i]);
        end
      end
    end
  endtask

  task automatic test_mid_change;
    logic [4:0] ea [4];
    logic [7:0] ed [4];
    int s, at; bit got, oth;
    ea = '{5'd12, 5'd13, 5'd14, 5'd15};
    ed = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
    s = wl_n;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd12; wdata0 = 32'hCAFEF00D;
    @(negedge clk);
    addr0 = 5'd24; wdata0 = 32'h12345678; req0 = 1'b0;
    wait_ack(0, got, at, oth);
    @(negedge clk);
    n_cmp++;
    if (!got || wl_n - s != 4) begin
      n_bad++; $display("FAIL mid_ack_count: got ack=%0d writes=%0d want 1/4", got, wl_n - s);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (wl_addr[s+i] !== ea[i] || wl_data[s+i] !== ed[i]) begin
          n_bad++; $display("FAIL mid_byte%0d: got %h@%0d want %h@%0d", i,
                            wl_data[s+i], wl_addr[s+i], ed[i], ea[i]);
        end
      end
    end
  endtask

  task automatic test_async_reset;
    int s, s2, at; bit got, oth;
    s = wl_n;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd16; wdata0 = 32'h9ABCDEF0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0; req0 = 1'b0;
    #1;
    n_cmp++;
    if ({mem_en, busy, ack0, mem_we} !== 4'b0000) begin
      n_bad++; $display("FAIL arst_immediate: got en%b busy%b ack0%b we%b want 0000", mem_en, busy, ack0, mem_we);
    end
    #1;
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    n_cmp++;
    if (wl_n - s != 2 || wl_addr[s] !== 5'd16 || wl_data[s] !== 8'h9A
        || wl_addr[s+1] !== 5'd17 || wl_data[s+1] !== 8'hBC) begin
      n_bad++; $display("FAIL arst_writes: got %0d writes (first %h@%0d) want 2 (9A@16, BC@17)",
                        wl_n - s, wl_data[s], wl_addr[s]);
    end
    n_cmp++;
    if (rdata1 !== 32'h0 || ack0 !== 1'b0) begin
      n_bad++; $display("FAIL arst_state: got rdata1=%h ack0=%b want 0/0", rdata1, ack0);
    end
    s2 = wl_n;
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd2; wdata0 = 32'h0A0B0C0D;
    @(negedge clk);
    n_cmp++;
    if (mem_addr !== 5'd2 || mem_wdata !== 8'h0A || mem_en !== 1'b1) begin
      n_bad++; $display("FAIL arst_restart: got en%b a%0d d%h want en1 a2 d0A", mem_en, mem_addr, mem_wdata);
    end
    wait_ack(0, got, at, oth);
    req0 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (!got || wl_n - s2 != 4 || wl_data[s2+3] !== 8'h0D || wl_addr[s2+3] !== 5'd5) begin
      n_bad++; $display("FAIL arst_next_txn: got ack=%0d writes=%0d want 1/4 ending 0D@5", got, wl_n - s2);
    end
  endtask

  task automatic test_contention;
    int c0, prev, s, who;
    bit got;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    s = wl_n;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd16; wdata0 = 32'h01020304;
    req1 = 1'b1; we1 = 1'b1; addr1 = 5'd20; wdata1 = 32'h05060708;
    @(negedge clk);
    c0 = cyc;
    prev = c0 - 2;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0; who = -1;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (ack0 && ack1) who = 2;
        else if (ack0) who = 0;
        else if (ack1) who = 1;
        if (ack0 || ack1) got = 1'b1;
      end
      if (k == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      n_cmp++;
      if (!got || who != (k % 2) || (cyc - prev) != 6) begin
        n_bad++; $display("FAIL tie_grant%0d: got ack=%0d port=%0d spacing=%0d want 1/%0d/6",
                          k, got, who, cyc - prev, k % 2);
      end
      prev = cyc;
    end
    @(negedge clk);
    n_cmp++;
    if (wl_n - s != 16 || wl_addr[s] !== 5'd16 || wl_addr[s+4] !== 5'd20
        || wl_addr[s+8] !== 5'd16 || wl_data[s+15] !== 8'h08) begin
      n_bad++; $display("FAIL tie_writes: got %0d writes a0=%0d a4=%0d want 16 a0=16 a4=20",
                        wl_n - s, wl_addr[s], wl_addr[s+4]);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read();
    test_wrap();
    test_mid_change();
    test_async_reset();
    test_contention();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
